// File: rtl/lr_check_arbiter.sv
// Round-robin front end that shares one registered left==right operand checker between NREQ requesters.
// Accept in IDLE, verdict registered in CMP, held in RSP until taken: rsp_valid rises two edges after accept.
module lr_check_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16,
    parameter int CNTW  = 16,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*4-1:0]     req_op,
    input  logic [NREQ*WIDTH-1:0] req_left,
    input  logic [NREQ*WIDTH-1:0] req_right,
    input  logic [NREQ-1:0]       req_const,
    input  logic [NREQ-1:0]       req_ignore,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  rsp_warn,
    output logic                  rsp_suppressed,
    input  logic                  cnt_clr,
    output logic [CNTW-1:0]       warn_count,
    output logic [CNTW-1:0]       supp_count
);

    typedef enum logic [1:0] {IDLE, CMP, RSP} state_t;

    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_ASHL  = 4'd6;
    localparam logic [3:0] OP_TIMES = 4'd9;
    localparam logic [3:0] OP_MOD   = 4'd13;

    state_t           state;
    logic [IDW-1:0]   rr_ptr;
    logic [IDW-1:0]   id_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] left_q;
    logic [WIDTH-1:0] right_q;
    logic             const_q;
    logic             ignore_q;

    logic             gnt_vld;
    logic [IDW-1:0]   gnt_idx;
    logic             raw_match;
    logic             warnable;
    logic             exempt;
    logic             hit;

    function automatic logic [IDW-1:0] wrap_idx(input int base, input int k);
        int s;
        s = base + k;
        if (s >= NREQ) s = s - NREQ;
        return s[IDW-1:0];
    endfunction

    // Scan starts one past the last served requester, so the last winner has lowest priority.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!gnt_vld && req_valid[wrap_idx(int'(rr_ptr), k)]) begin
                gnt_vld = 1'b1;
                gnt_idx = wrap_idx(int'(rr_ptr), k);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && gnt_vld) req_ready[gnt_idx] = 1'b1;
    end

    // Shift-by-one of two literals (1<<1) is an idiom, not a copy/paste slip.
    always_comb begin
        raw_match = (left_q == right_q);
        warnable  = (op_q != OP_TIMES) && (op_q <= OP_MOD);
        exempt    = ((op_q == OP_SHL) || (op_q == OP_ASHL)) && const_q &&
                    (left_q == WIDTH'(1)) && (right_q == WIDTH'(1));
        hit       = raw_match && warnable && !exempt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            rr_ptr         <= IDW'(NREQ - 1);
            id_q           <= '0;
            op_q           <= '0;
            left_q         <= '0;
            right_q        <= '0;
            const_q        <= 1'b0;
            ignore_q       <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_id         <= '0;
            rsp_warn       <= 1'b0;
            rsp_suppressed <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        id_q     <= gnt_idx;
                        op_q     <= req_op[int'(gnt_idx)*4 +: 4];
                        left_q   <= req_left[int'(gnt_idx)*WIDTH +: WIDTH];
                        right_q  <= req_right[int'(gnt_idx)*WIDTH +: WIDTH];
                        const_q  <= req_const[gnt_idx];
                        ignore_q <= req_ignore[gnt_idx];
                        state    <= CMP;
                    end
                end
                CMP: begin
                    rsp_id         <= id_q;
                    rsp_warn       <= hit && !ignore_q;
                    rsp_suppressed <= hit && ignore_q;
                    rsp_valid      <= 1'b1;
                    state          <= RSP;
                end
                RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= id_q;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Clear wins over a coincident increment; counts stick at all-ones.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            warn_count <= '0;
            supp_count <= '0;
        end else if (cnt_clr) begin
            warn_count <= '0;
            supp_count <= '0;
        end else if (state == RSP && rsp_valid && rsp_ready) begin
            if (rsp_warn && warn_count != '1)       warn_count <= warn_count + 1'b1;
            if (rsp_suppressed && supp_count != '1) supp_count <= supp_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_lr_check_arbiter.sv
// Directed bench for lr_check_arbiter; a second copy with 3-bit counters sees the same stimulus to exercise saturation.
module tb_lr_check_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 16;
    localparam int CNTW  = 16;
    localparam int SCNTW = 3;

    logic                  clk = 1'b0;
    logic                  reset_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*4-1:0]     req_op;
    logic [NREQ*WIDTH-1:0] req_left;
    logic [NREQ*WIDTH-1:0] req_right;
    logic [NREQ-1:0]       req_const;
    logic [NREQ-1:0]       req_ignore;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic                  rsp_warn;
    logic                  rsp_suppressed;
    logic                  cnt_clr;
    logic [CNTW-1:0]       warn_count;
    logic [CNTW-1:0]       supp_count;

    logic [NREQ-1:0]       s_req_ready;
    logic                  s_rsp_valid;
    logic [1:0]            s_rsp_id;
    logic                  s_rsp_warn;
    logic                  s_rsp_suppressed;
    logic [SCNTW-1:0]      s_warn_count;
    logic [SCNTW-1:0]      s_supp_count;

    int n_chk = 0;
    int n_bad = 0;
    int exp_wc = 0;
    int exp_sc = 0;
    int exp_sw = 0;

    always #5 clk = ~clk;

    lr_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_left(req_left), .req_right(req_right),
        .req_const(req_const), .req_ignore(req_ignore),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_warn(rsp_warn), .rsp_suppressed(rsp_suppressed),
        .cnt_clr(cnt_clr), .warn_count(warn_count), .supp_count(supp_count)
    );

    lr_check_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .CNTW(SCNTW)) dut_s (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op),
        .req_left(req_left), .req_right(req_right),
        .req_const(req_const), .req_ignore(req_ignore),
        .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
        .rsp_warn(s_rsp_warn), .rsp_suppressed(s_rsp_suppressed),
        .cnt_clr(cnt_clr), .warn_count(s_warn_count), .supp_count(s_supp_count)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [15:0] l,
                           input logic [15:0] r, input logic c, input logic ig);
        req_op[i*4 +: 4]         = op;
        req_left[i*WIDTH +: WIDTH]  = l;
        req_right[i*WIDTH +: WIDTH] = r;
        req_const[i]  = c;
        req_ignore[i] = ig;
    endtask

    task automatic wait_gnt(input int i);
        int n;
        n = 0;
        while (req_ready[i] !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("gnt", 32'(req_ready), 32'(1) << i);
    endtask

    // One request through the whole pipe; called at posedge+1 with the DUT idle.
    task automatic do_txn(input string tag, input int i, input logic [3:0] op,
                          input logic [15:0] l, input logic [15:0] r, input logic c,
                          input logic ig, input logic ew, input logic es, input logic clr);
        set_req(i, op, l, r, c, ig);
        req_valid[i] = 1'b1;
        #1;
        wait_gnt(i);
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
        chk({tag, "_lat1"}, 32'(rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(i));
        chk({tag, "_warn"}, 32'(rsp_warn), 32'(ew));
        chk({tag, "_supp"}, 32'(rsp_suppressed), 32'(es));
        cnt_clr = clr;
        if (clr) begin
            exp_wc = 0; exp_sc = 0; exp_sw = 0;
        end else begin
            if (ew) exp_wc++;
            if (es) exp_sc++;
            if (ew && exp_sw < 7) exp_sw++;
        end
        @(posedge clk); #1;
        cnt_clr = 1'b0;
        chk({tag, "_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_wc"}, 32'(warn_count), 32'(exp_wc));
        chk({tag, "_sc"}, 32'(supp_count), 32'(exp_sc));
        chk({tag, "_sat_wc"}, 32'(s_warn_count), 32'(exp_sw));
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_op = '0; req_left = '0; req_right = '0;
        req_const = '0; req_ignore = '0; rsp_ready = 1'b1; cnt_clr = 1'b0;
        #12;
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_warn", 32'(rsp_warn), 32'd0);
        chk("rst_supp", 32'(rsp_suppressed), 32'd0);
        chk("rst_wc", 32'(warn_count), 32'd0);
        chk("rst_sc", 32'(supp_count), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_rdy", 32'(req_ready), 32'd0);
        chk("idle_vld", 32'(rsp_valid), 32'd0);

        do_txn("and_eq",   0, 4'd0,  16'h00A5, 16'h00A5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("shl_11",   0, 4'd5,  16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("ashl_11",  1, 4'd6,  16'd1, 16'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("shr_11",   0, 4'd7,  16'd1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("shl_22",   0, 4'd5,  16'd2, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("times",    2, 4'd9,  16'd7, 16'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("plus_ne",  3, 4'd10, 16'd5, 16'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("minus",    1, 4'd11, 16'd9, 16'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("mod_ign",  2, 4'd13, 16'd3, 16'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        do_txn("resv14",   3, 4'd14, 16'd5, 16'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_txn("msb_ne",   0, 4'd2,  16'h8001, 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Push the 3-bit counter copy past 7 so it must stick.
        do_txn("eq",       1, 4'd2,  16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("lt",       2, 4'd3,  16'd4, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("lte",      3, 4'd4,  16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("qmark",    0, 4'd12, 16'h1234, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("ashr_11",  1, 4'd8,  16'd1, 16'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        do_txn("or_clr",   2, 4'd1,  16'd4, 16'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        do_txn("post_clr", 3, 4'd0,  16'd0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

        // Reset while the verdict is being computed.
        set_req(0, 4'd0, 16'd8, 16'd8, 1'b0, 1'b0);
        req_valid[0] = 1'b1;
        #1;
        wait_gnt(0);
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_wc", 32'(warn_count), 32'd0);
        chk("mid_rst_sc", 32'(supp_count), 32'd0);
        #2;
        reset_n = 1'b1;
        exp_wc = 0;

        // All requesters busy: order 0,1,2,3,0 from the post-reset pointer.
        for (int i = 0; i < NREQ; i++) set_req(i, 4'd10, 16'(i), 16'(i), 1'b0, 1'b0);
        req_valid = '1;
        #1;
        for (int g = 0; g < 5; g++) begin
            int n;
            n = 0;
            while (req_ready == '0 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
            chk("rr_gnt", 32'(req_ready), 32'(1) << (g % 4));
            if (g == 1) rsp_ready = 1'b0;
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk("rr_id", 32'(rsp_id), 32'(g % 4));
            if (g == 1) begin
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk); #1;
                    chk("stall_vld", 32'(rsp_valid), 32'd1);
                    chk("stall_id", 32'(rsp_id), 32'd1);
                    chk("stall_warn", 32'(rsp_warn), 32'd1);
                    chk("stall_rdy", 32'(req_ready), 32'd0);
                end
                rsp_ready = 1'b1;
            end
            exp_wc++;
        end
        @(posedge clk); #1;
        req_valid = '0;
        chk("rr_wc", 32'(warn_count), 32'(exp_wc));
        chk("rr_sc", 32'(supp_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/lr_check_arbiter.md
Name: lr_check_arbiter

Overview:
- Shares one registered left/right operand-equality checker between NREQ requesters. Each requester submits one binary-operator instance: an opcode plus its left and right operands.
- The block arbitrates round-robin, compares the operands, applies the operator exemption rules, and returns a warn/no-warn verdict with the requester ID.
- It sits behind the expression-walk front ends and ahead of the warning collector.
- It also keeps saturating counts of warnings issued and warnings suppressed.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, operand width in bits
- CNTW, 16, width of each statistics counter

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester accept strobe, one-hot or zero
- req_op  in  NREQ*4  per-requester opcode, slice i at [4i+3:4i]
- req_left  in  NREQ*WIDTH  left operand, slice i
- req_right  in  NREQ*WIDTH  right operand, slice i
- req_const  in  NREQ  both operands are literals
- req_ignore  in  NREQ  lint-ignore pragma active on this instance
- rsp_valid  out  1  verdict valid
- rsp_ready  in  1  collector accepts verdict
- rsp_id  out  $clog2(NREQ)  requester index of verdict
- rsp_warn  out  1  warning issued
- rsp_suppressed  out  1  would warn, but req_ignore was set
- cnt_clr  in  1  synchronous clear of both counters
- warn_count  out  CNTW  saturating count of issued warnings
- supp_count  out  CNTW  saturating count of suppressed warnings

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, rr_ptr=NREQ-1
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_warn=0, rsp_suppressed=0
  - both counters=0
- Opcode map:
  - 0 AND, 1 OR, 2 EQ, 3 LT, 4 LTE, 5 SHL, 6 ASHL, 7 SHR, 8 ASHR
  - 9 TIMES, 10 PLUS, 11 MINUS, 12 QMARK (left=then-arm, right=else-arm), 13 MOD
  - 14-15 reserved.
- Raw match: left==right, full-width unsigned compare.
- Warnable opcodes: 0-8 and 10-13.
  - TIMES (9) never warns.
  - Reserved opcodes (14, 15) never warn.
- Exemption: op SHL or ASHL with req_const=1, left==1 and right==1 never warns.
  - SHR and ASHR with 1,1 still warn.
  - 2<<2 still warns.
- hit = raw match & warnable & ~exempt.
  - rsp_warn = hit & ~ignore
  - rsp_suppressed = hit & ignore
  - rsp_warn and rsp_suppressed are never both 1.
- FSM states: IDLE, CMP, RSP.
  - IDLE: if any req_valid, grant g = first valid index scanning rr_ptr+1, rr_ptr+2, … modulo NREQ. Same cycle: req_ready[g]=1 (combinational, single cycle), latch op/left/right/const/ignore/g, go to CMP. Else stay in IDLE.
  - CMP: register the verdict into rsp_*, set rsp_valid=1, go to RSP.
  - RSP: hold rsp_* stable while rsp_ready=0. On rsp_valid&rsp_ready: rsp_valid=0, rr_ptr=g, update counters, go to IDLE.
- Latency: accept at cycle T; rsp_valid rises at edge T+2. Best-case throughput is one verdict per 3 cycles.
- req_ready is 0 in CMP and RSP. A requester holds valid and payload until it sees req_ready.
- req_valid dropped before grant: no grant, no side effect.
- Fairness: a continuously requesting requester is served within NREQ grants.
- Counters:
  - Increment on the response handshake: warn_count if rsp_warn, supp_count if rsp_suppressed.
  - Saturate at 2^CNTW-1 with no wrap.
  - cnt_clr has priority over a simultaneous increment: result is 0.
- Reset asserted mid-transaction: the in-flight verdict is discarded and no counter updates. After release, arbitration restarts from requester 0.

Test Plan:
- Single requester 0 sends op=AND, left=right=16'h00A5 → req_ready[0] at T, rsp_valid at T+2, rsp_id=0, rsp_warn=1, warn_count=1.
- op=SHL, const=1, left=right=1 → rsp_warn=0. Repeat with op=SHR → rsp_warn=1. Repeat with op=SHL, left=right=2 → rsp_warn=1.
- op=TIMES, left=right=7 → rsp_warn=0. op=PLUS, left=5, right=6 → rsp_warn=0. op=MINUS, left=right=9 → rsp_warn=1.
- op=MOD, left=right=3, ignore=1 → rsp_warn=0, rsp_suppressed=1, supp_count increments, warn_count unchanged.
- All four requesters valid continuously, rsp_ready=1 → grant order 0,1,2,3,0; rsp_ready held 0 for 5 cycles → rsp_* stable, req_ready all 0.
- Preload warn_count=16'hFFFF, then a warning → stays at FFFF. cnt_clr coincident with a warn handshake → 0. reset_n pulsed low during CMP → rsp_valid=0, counters=0, next grant goes to the lowest valid index.
